// File: rtl/mips_multicycle_control.sv
// Multi-cycle main control FSM for the MIPS_32 core: sequences fetch, decode,
// execute, memory and writeback steps and drives the shared-ALU datapath controls.
module mips_multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam int unsigned ST_W = 4;
   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef enum logic [ST_W-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11,
      S_ILLEGAL   = 4'd12
   } state_e;

   state_e state_q, state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next state and Moore outputs; only FETCH's IRWrite/PCWrite look at mem_ready.
   always_comb begin
      state_d     = S_FETCH;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALU_ADD;
      PCSource    = PCS_ALU;
      illegal_op  = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            state_d = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM2;
            case (opcode)
               OP_RTYPE:      state_d = S_EXECUTE;
               OP_LW, OP_SW:  state_d = S_MEM_ADDR;
               OP_BEQ:        state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               OP_ADDI:       state_d = S_ADDI_EXEC;
               default:       state_d = S_ILLEGAL;
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            state_d  = mem_ready ? S_FETCH : S_MEM_WRITE;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUNCT;
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCS_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCS_JUMP;
         end
         S_ADDI_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            RegWrite = 1'b1;
         end
         S_ILLEGAL: begin
            illegal_op = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset silences every enable, including FETCH's read request.
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         MemtoReg    = 1'b0;
         RegDst      = 1'b0;
         RegWrite    = 1'b0;
         ALUSrcA     = 1'b0;
         ALUSrcB     = SRCB_REG;
         ALUOp       = ALU_ADD;
         PCSource    = PCS_ALU;
         illegal_op  = 1'b0;
      end
   end

   assign state = reset ? ST_W'(0) : ST_W'(state_q);

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle main control FSM for the MIPS_32 core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback steps. Each cycle it drives the ALUOp code consumed by ALU_Control, the ALU operand selects, and the PC, IR, memory and register-file enables. Sits between the instruction register's opcode field and the shared single-ALU datapath, and stalls on a memory ready handshake.

## Interface
Parameters: none.

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces FETCH
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- MemtoReg  out  1  1 = writeback from MDR
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 subtract, 10 use funct field
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state code (debug)

## Operation
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, ILLEGAL 12. Codes 13–15 go to FETCH on the next edge with all outputs 0.
- Outputs are Moore and default to 0. The one exception is FETCH, where IRWrite and PCWrite are qualified by mem_ready.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Holds until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - 000000 → EXECUTE
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EXEC
  - any other → ILLEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ if opcode=100011, otherwise MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until mem_ready, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then ALU_WB.
- ALU_WB: RegDst=1, RegWrite=1, MemtoReg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then ADDI_WB.
- ADDI_WB: RegDst=0, RegWrite=1, MemtoReg=0. Then FETCH.
- ILLEGAL: illegal_op=1, no other enables. Then FETCH, so the PC has already advanced past the bad word.
- opcode is don't-care in every state except DECODE and MEM_ADDR.
- ALUOp=11 is never driven.

## Timing
- Reset: state=FETCH immediately (asynchronous). While reset is high, every output is forced 0, including the FETCH outputs and state, which reads 0.
- First FETCH request appears in the cycle after reset deasserts.
- Deassertion is synchronized externally; the block needs no internal synchronizer.
- Cycles per instruction with mem_ready held 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 3
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Request signals stay stable throughout the wait.
- mem_ready is ignored in all other states.
- Reset mid-instruction: abandon the instruction and return to FETCH with no residual enables. No partial writeback occurs after reset asserts.
- illegal_op is high for exactly one cycle per offending instruction.

## Test plan
- Reset asserted mid-EXECUTE, mem_ready=1, release → all outputs 0 during reset. Cycle 1 after release is FETCH with MemRead=1, IRWrite=1, PCWrite=1, state=0.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0. ALUOp 00 in states 0–2. RegWrite=1 and MemtoReg=1 only in state 4.
- sw (101011) with mem_ready low for 2 cycles in MEM_WRITE → MemWrite=1 held 3 cycles, IorD=1 throughout. Returns to FETCH after the ready cycle.
- R-type (000000) then beq (000100) → EXECUTE drives ALUOp=10 then ALU_WB drives RegDst=1 and RegWrite=1. BRANCH drives ALUOp=01, PCWriteCond=1, PCSource=01.
- j (000010) then addi (001000) → JUMP drives PCWrite=1, PCSource=10. ADDI path runs 10 then 11 with ALUSrcB=10, then RegWrite=1 with RegDst=0.
- opcode 111111 in DECODE → state 12 for one cycle, illegal_op=1, all enables 0, then FETCH.
- FETCH with mem_ready low for 3 cycles → IRWrite=PCWrite=0 for 3 cycles, then pulse together for 1 cycle.
